fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
Sequencer for the EX-stage operand forwarding muxes (3-input, 2-bit select) and the pipeline hazard control of the 5-stage RISC-V core.
- Keeps a shadow copy of destination/write-enable/load info for the ID/EX, EX/MEM and MEM/WB stages.
- Drives the rs1/rs2 forwarding selects.
- Detects load-use hazards and inserts bubbles.
- Handles branch flush and data-memory wait freezes.
- Keeps saturating stall/flush counters.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_ADDR_W  ID source register 1
id_rs2  in  REG_ADDR_W  ID source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_rd  in  REG_ADDR_W  ID destination register
id_regwrite  in  1  ID instruction writes rd
id_memread  in  1  ID instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jump
mem_wait  in  1  data memory not ready; freeze pipeline
fwd_a_sel  out  2  select for rs1 forwarding mux
fwd_b_sel  out  2  select for rs2 forwarding mux
stall_if_id  out  1  hold PC and IF/ID register
flush_if_id  out  1  squash IF/ID contents
bubble_id_ex  out  1  load NOP into ID/EX
pipe_hold  out  1  freeze all pipeline registers
stall_count  out  CNT_W  load-use stall cycles, saturating
flush_count  out  CNT_W  flush events, saturating

Behaviour:
- Select encoding:
  - 0 = register-file operand
  - 1 = EX/MEM ALU result
  - 2 = MEM/WB writeback value
  - 3 = reserved, never driven
- Shadow stages (sIDEX, sEXMEM, sMEMWB) hold: valid, rd, regwrite, memread. sIDEX also holds rs1, rs2, uses_rs1, uses_rs2.
- Each rising clk with mem_wait=0:
  - sMEMWB <= sEXMEM
  - sEXMEM <= sIDEX
  - sIDEX <= bubble (valid=0) if bubble_id_ex, else the ID fields with valid=id_valid.
- mem_wait=1: all shadow stages and counters hold. pipe_hold=mem_wait (combinational). Selects stay driven from the held state.
- Forward select for rs1 (rs2 symmetric), combinational from shadow registers, same cycle:
  - Default 0; also 0 if sIDEX.valid=0 or uses_rs1=0.
  - Result 1 if sEXMEM.valid & regwrite & !memread & rd!=0 & rd==sIDEX.rs1.
  - Otherwise result 2 if sMEMWB.valid & regwrite & rd!=0 & rd==sIDEX.rs1.
  - EX/MEM has priority (newest value).
  - x0 is never forwarded.
- Load-use (lu):
  - id_valid & sIDEX.valid & sIDEX.memread & sIDEX.rd!=0 & ((id_uses_rs1 & id_rs1==sIDEX.rd) | (id_uses_rs2 & id_rs2==sIDEX.rd)).
  - Gives exactly one bubble; the load then reaches MEM/WB when the consumer is in EX, so select 2 applies.
- Outputs:
  - stall_if_id = lu & !ex_branch_taken
  - flush_if_id = ex_branch_taken
  - bubble_id_ex = lu | ex_branch_taken
- Flush has priority over stall: a load-use condition against a squashed instruction is ignored.
- Counters (update only when mem_wait=0):
  - stall_count +1 per cycle with stall_if_id=1
  - flush_count +1 per cycle with flush_if_id=1
  - Both saturate at all-ones, no wrap.
- Register file is write-through in WB. A WB→ID same-cycle dependency needs no action here.
- Reset (async, rst_n=0):
  - All shadow valid=0, all fields 0.
  - Counters 0, hence selects 0 and stall/flush/bubble 0. pipe_hold follows mem_wait.
  - Reset mid-operation discards all in-flight tracking immediately. The first cycle after release behaves as an empty pipeline.

Decomposition:
- Shared package fwd_pkg:
  - FWD_RF=2'd0, FWD_EXMEM=2'd1, FWD_MEMWB=2'd2
  - REG_ADDR_W default
  - packed stage-info struct {valid, rd, regwrite, memread}
- One sub-module, fwd_sel_unit: combinational compare of one source register against sEXMEM/sMEMWB, returning a 2-bit select. Instantiated twice (rs1, rs2).

Test Plan:
- Back-to-back ALU: add x5 ← …, then sub uses x5 as rs1 next cycle → while sub in EX, fwd_a_sel=1, fwd_b_sel=0, no stall.
- Distance 2: add x7, nop, and rs2=x7 → fwd_b_sel=2. Same with EX/MEM also writing x7 → fwd_b_sel=1 (priority).
- Load-use: lw x3, then add x4,x3,x1 → stall_if_id=1 and bubble_id_ex=1 for exactly one cycle, stall_count=1; next EX cycle fwd_a_sel=2. Writes to x0 never forward or stall.
- Branch with concurrent load-use: ex_branch_taken=1 in the same cycle as the lu condition → flush_if_id=1, bubble_id_ex=1, stall_if_id=0, flush_count+1, stall_count unchanged.
- mem_wait=1 for 3 cycles mid-sequence → pipe_hold=1, selects and counters frozen; resume gives identical select sequence shifted by 3 cycles.
- rst_n pulled low mid-stall, asynchronously between edges → all outputs 0 immediately. Preload counters to all-ones via repeated stalls → saturation holds at 0xFFFF.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the EX-stage forwarding / hazard control.
//   FWD_*        : forwarding mux select encoding (3 = reserved, never driven)
//   REG_ADDR_W   : default register index width
//   stage_info_t : per-stage shadow info {valid, rd, regwrite, memread}
package fwd_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'd0;  // register-file operand
  localparam logic [1:0] FWD_EXMEM = 2'd1;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'd2;  // MEM/WB writeback value

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_info_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: combinational forwarding select for one EX source operand.
//   src_used : operand is live (ID/EX valid and the instruction reads it)
//   src_reg  : source register index held in ID/EX
//   exmem    : shadow info of the EX/MEM stage
//   memwb    : shadow info of the MEM/WB stage
//   sel      : FWD_RF / FWD_EXMEM / FWD_MEMWB
module fwd_sel_unit
  import fwd_pkg::*;
(
  input  logic                  src_used,
  input  logic [REG_ADDR_W-1:0] src_reg,
  input  stage_info_t           exmem,
  input  stage_info_t           memwb,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_RF;
    if (src_used) begin
      // A load in EX/MEM has no data yet; the load-use bubble guarantees it
      // is picked up from MEM/WB one cycle later instead.
      if (exmem.valid && exmem.regwrite && !exmem.memread &&
          (exmem.rd != '0) && (exmem.rd == src_reg)) begin
        sel = FWD_EXMEM;
      end else if (memwb.valid && memwb.regwrite &&
                   (memwb.rd != '0) && (memwb.rd == src_reg)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand forwarding selects and hazard control for the
// 5-stage RISC-V pipeline.
//   clk, rst_n            : clock (rising edge), async active-low reset
//   id_*                  : decoded fields of the instruction currently in ID
//   ex_branch_taken       : taken branch/jump resolved in EX
//   mem_wait              : data memory busy, whole pipeline frozen
//   fwd_a_sel, fwd_b_sel  : rs1/rs2 forwarding mux selects for EX
//   stall_if_id           : hold PC and IF/ID
//   flush_if_id           : squash IF/ID
//   bubble_id_ex          : load a NOP into ID/EX
//   pipe_hold             : freeze all pipeline registers (= mem_wait)
//   stall_count           : saturating count of load-use stall cycles
//   flush_count           : saturating count of flush cycles
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_branch_taken,
  input  logic                  mem_wait,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic                  pipe_hold,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  import fwd_pkg::*;

  // Shadow pipeline state
  stage_info_t           idex_reg, exmem_reg, memwb_reg;
  logic [REG_ADDR_W-1:0] idex_rs1_reg, idex_rs2_reg;
  logic                  idex_uses_rs1_reg, idex_uses_rs2_reg;
  logic [CNT_W-1:0]      stall_cnt_reg, flush_cnt_reg;

  logic                  load_use;

  // Forwarding selects: one compare unit per source operand
  logic                  src_used [2];
  logic [REG_ADDR_W-1:0] src_reg  [2];
  logic [1:0]            src_sel  [2];

  assign src_used[0] = idex_reg.valid & idex_uses_rs1_reg;
  assign src_used[1] = idex_reg.valid & idex_uses_rs2_reg;
  assign src_reg[0]  = idex_rs1_reg;
  assign src_reg[1]  = idex_rs2_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sel
      fwd_sel_unit u_sel (
        .src_used (src_used[gi]),
        .src_reg  (src_reg[gi]),
        .exmem    (exmem_reg),
        .memwb    (memwb_reg),
        .sel      (src_sel[gi])
      );
    end
  endgenerate

  assign fwd_a_sel = src_sel[0];
  assign fwd_b_sel = src_sel[1];

  // Load in ID/EX whose result the ID instruction needs next cycle
  always_comb begin
    load_use = id_valid && idex_reg.valid && idex_reg.memread && (idex_reg.rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == idex_reg.rd)) ||
                (id_uses_rs2 && (id_rs2 == idex_reg.rd)));
  end

  // A taken branch squashes the ID instruction, so its load-use is moot
  assign stall_if_id  = load_use & ~ex_branch_taken;
  assign flush_if_id  = ex_branch_taken;
  assign bubble_id_ex = load_use | ex_branch_taken;
  assign pipe_hold    = mem_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_reg          <= '0;
      exmem_reg         <= '0;
      memwb_reg         <= '0;
      idex_rs1_reg      <= '0;
      idex_rs2_reg      <= '0;
      idex_uses_rs1_reg <= 1'b0;
      idex_uses_rs2_reg <= 1'b0;
    end else if (!mem_wait) begin
      memwb_reg <= exmem_reg;
      exmem_reg <= idex_reg;
      if (bubble_id_ex) begin
        idex_reg          <= '0;
        idex_rs1_reg      <= '0;
        idex_rs2_reg      <= '0;
        idex_uses_rs1_reg <= 1'b0;
        idex_uses_rs2_reg <= 1'b0;
      end else begin
        idex_reg.valid    <= id_valid;
        idex_reg.rd       <= id_rd;
        idex_reg.regwrite <= id_regwrite;
        idex_reg.memread  <= id_memread;
        idex_rs1_reg      <= id_rs1;
        idex_rs2_reg      <= id_rs2;
        idex_uses_rs1_reg <= id_uses_rs1;
        idex_uses_rs2_reg <= id_uses_rs2;
      end
    end
  end

  // Saturating event counters, frozen together with the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (!mem_wait) begin
      if (stall_if_id && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_if_id && (flush_cnt_reg != '1)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_count = stall_cnt_reg;
  assign flush_count = flush_cnt_reg;

endmodule
